// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared phase encoding, direction codes and per-phase lamp patterns
// for the intersection phase scheduler.
package intersection_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    NS_AR = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    EW_AR = 3'd5,
    PED   = 3'd6
  } state_t;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  // Lamp vector order: {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}
  localparam logic [5:0] LAMPS_NS_G    = 6'b100_001;
  localparam logic [5:0] LAMPS_NS_Y    = 6'b010_001;
  localparam logic [5:0] LAMPS_EW_G    = 6'b001_100;
  localparam logic [5:0] LAMPS_EW_Y    = 6'b001_010;
  localparam logic [5:0] LAMPS_ALL_RED = 6'b001_001;

  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      NS_G:    lamps_of = LAMPS_NS_G;
      NS_Y:    lamps_of = LAMPS_NS_Y;
      EW_G:    lamps_of = LAMPS_EW_G;
      EW_Y:    lamps_of = LAMPS_EW_Y;
      default: lamps_of = LAMPS_ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Per-phase tick counter: clears on phase change, saturates at limit-1 and
// flags the tick that completes a phase of length limit.
module intersection_phase_scheduler_phase_timer
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] cnt,
  output logic          done
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] last_val;

  assign last_val = limit - CW'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (tick && (cnt_reg < last_val)) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign done = tick && (cnt_reg == last_val);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Actuated two-way intersection phase scheduler: green/yellow/all-red/walk
// sequencing with car demand, latched walk requests and emergency preemption.
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int G_MIN      = 5,
  parameter int Y_TICKS    = 2,
  parameter int AR_TICKS   = 1,
  parameter int WALK_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       emg_req,
  input  logic       emg_dir,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  localparam int MAX_A = (G_MIN > Y_TICKS) ? G_MIN : Y_TICKS;
  localparam int MAX_B = (AR_TICKS > WALK_TICKS) ? AR_TICKS : WALK_TICKS;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_T) + 1;

  state_t        state_reg, state_next;
  logic          ped_pending_reg;
  logic          last_dir_reg;
  logic          ped_ack_reg;
  logic [CW-1:0] limit;
  logic [CW-1:0] tick_cnt;
  logic          tmr_done;
  logic          state_change;
  logic          enter_ped;
  state_t        emg_green;

  assign state_change = (state_next != state_reg);
  assign enter_ped    = (state_next == PED) && (state_reg != PED);
  assign emg_green    = (emg_dir == DIR_EW) ? EW_G : NS_G;

  always_comb begin
    limit = CW'(1);
    case (state_reg)
      NS_G, EW_G:   limit = CW'(G_MIN);
      NS_Y, EW_Y:   limit = CW'(Y_TICKS);
      NS_AR, EW_AR: limit = CW'(AR_TICKS);
      PED:          limit = CW'(WALK_TICKS);
      default:      limit = CW'(1);
    endcase
  end

  intersection_phase_scheduler_phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_change),
    .tick  (tick),
    .limit (limit),
    .cnt   (tick_cnt),
    .done  (tmr_done)
  );

  // An emergency for the current green holds it; one for the cross
  // direction cuts it short immediately, without waiting for a tick.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      NS_G: begin
        if (emg_req) begin
          if (emg_dir == DIR_EW) state_next = NS_Y;
        end else if (tmr_done && (ew_car || ped_pending_reg)) begin
          state_next = NS_Y;
        end
      end
      EW_G: begin
        if (emg_req) begin
          if (emg_dir == DIR_NS) state_next = EW_Y;
        end else if (tmr_done && (ns_car || ped_pending_reg)) begin
          state_next = EW_Y;
        end
      end
      NS_Y: if (tmr_done) state_next = NS_AR;
      EW_Y: if (tmr_done) state_next = EW_AR;
      NS_AR: begin
        if (tmr_done) begin
          if (emg_req)              state_next = emg_green;
          else if (ped_pending_reg) state_next = PED;
          else                      state_next = EW_G;
        end
      end
      EW_AR: begin
        if (tmr_done) begin
          if (emg_req)              state_next = emg_green;
          else if (ped_pending_reg) state_next = PED;
          else                      state_next = NS_G;
        end
      end
      PED: begin
        if (tmr_done) begin
          if (emg_req)                     state_next = emg_green;
          else if (last_dir_reg == DIR_NS) state_next = EW_G;
          else                             state_next = NS_G;
        end
      end
      default: state_next = NS_AR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= NS_G;
      ped_pending_reg <= 1'b0;
      last_dir_reg    <= DIR_NS;
      ped_ack_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ped_ack_reg <= enter_ped;
      // A new press on the entry clock survives the clear
      if (ped_req)        ped_pending_reg <= 1'b1;
      else if (enter_ped) ped_pending_reg <= 1'b0;
      if (state_next == NS_G)      last_dir_reg <= DIR_NS;
      else if (state_next == EW_G) last_dir_reg <= DIR_EW;
    end
  end

  assign {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = lamps_of(state_reg);
  assign walk    = (state_reg == PED);
  assign ped_ack = ped_ack_reg;
  assign phase   = state_reg;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed, table-driven bench for intersection_phase_scheduler: one tick per
// four clocks, each table row is one tick period followed by a check.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst, tick, ns_car, ew_car, ped_req, emg_req, emg_dir;
  logic       ns_g, ns_y, ns_r, ew_g, ew_y, ew_r, walk, ped_ack;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       ns_car;
    logic       ew_car;
    logic       ped_req;
    logic       emg_req;
    logic       emg_dir;
    logic [2:0] exp_phase;
    int         exp_ack;
  } vec_t;

  localparam int NVEC = 52;
  vec_t vecs[NVEC];

  intersection_phase_scheduler dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .ns_car  (ns_car),
    .ew_car  (ew_car),
    .ped_req (ped_req),
    .emg_req (emg_req),
    .emg_dir (emg_dir),
    .ns_g    (ns_g),
    .ns_y    (ns_y),
    .ns_r    (ns_r),
    .ew_g    (ew_g),
    .ew_y    (ew_y),
    .ew_r    (ew_r),
    .walk    (walk),
    .ped_ack (ped_ack),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  // Expected lamps {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} for a phase code
  function automatic logic [5:0] exp_lamps(input logic [2:0] ph);
    case (ph)
      3'd0:    exp_lamps = 6'b100001;
      3'd1:    exp_lamps = 6'b010001;
      3'd3:    exp_lamps = 6'b001100;
      3'd4:    exp_lamps = 6'b001010;
      default: exp_lamps = 6'b001001;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic nc, input logic ec, input logic pr,
                         input logic er, input logic ed, input logic [2:0] ph, input int ack);
    vecs[i] = '{ns_car: nc, ew_car: ec, ped_req: pr, emg_req: er, emg_dir: ed,
                exp_phase: ph, exp_ack: ack};
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] ph);
    logic [5:0] lamps;
    lamps = {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    check($sformatf("%s.phase", tag), int'(phase), int'(ph));
    check($sformatf("%s.lamps", tag), int'(lamps), int'(exp_lamps(ph)));
    check($sformatf("%s.walk", tag), int'(walk), (ph == 3'd6) ? 1 : 0);
  endtask

  // One tick period: tick on the first of four clocks; counts ped_ack clocks
  task automatic tick_period(output int ack_cnt);
    ack_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick = (k == 0);
      @(posedge clk);
      #1;
      if (ped_ack) ack_cnt++;
    end
    tick = 1'b0;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int ack_cnt;
    for (int i = lo; i <= hi; i++) begin
      ns_car  = vecs[i].ns_car;
      ew_car  = vecs[i].ew_car;
      ped_req = vecs[i].ped_req;
      emg_req = vecs[i].emg_req;
      emg_dir = vecs[i].emg_dir;
      tick_period(ack_cnt);
      check_outputs($sformatf("v%0d", i), vecs[i].exp_phase);
      check($sformatf("v%0d.ped_ack", i), ack_cnt, vecs[i].exp_ack);
      $display("vec %0d: phase=%0d walk=%0d ped_ack_clocks=%0d", i, phase, walk, ack_cnt);
    end
  endtask

  initial begin
    // Car demand on EW from reset
    for (int i = 0; i < 4; i++) set_vec(i, 0, 1, 0, 0, 0, 3'd0, 0);
    set_vec(4, 0, 1, 0, 0, 0, 3'd1, 0);
    set_vec(5, 0, 1, 0, 0, 0, 3'd1, 0);
    set_vec(6, 0, 1, 0, 0, 0, 3'd2, 0);
    set_vec(7, 0, 1, 0, 0, 0, 3'd3, 0);
    // Walk request in EW_G, no cars
    set_vec(8, 0, 0, 1, 0, 0, 3'd3, 0);
    for (int i = 9; i < 12; i++) set_vec(i, 0, 0, 0, 0, 0, 3'd3, 0);
    set_vec(12, 0, 0, 0, 0, 0, 3'd4, 0);
    set_vec(13, 0, 0, 0, 0, 0, 3'd4, 0);
    set_vec(14, 0, 0, 0, 0, 0, 3'd5, 0);
    set_vec(15, 0, 0, 0, 0, 0, 3'd6, 1);
    for (int i = 16; i < 19; i++) set_vec(i, 0, 0, 0, 0, 0, 3'd6, 0);
    set_vec(19, 0, 0, 0, 0, 0, 3'd0, 0);
    set_vec(20, 0, 0, 0, 0, 0, 3'd0, 0);
    // After EW preemption of NS_G
    set_vec(21, 0, 0, 0, 1, 1, 3'd1, 0);
    set_vec(22, 0, 0, 0, 1, 1, 3'd2, 0);
    set_vec(23, 0, 0, 0, 1, 1, 3'd3, 0);
    for (int i = 24; i < 32; i++) set_vec(i, 1, 0, 0, 1, 1, 3'd3, 0);
    set_vec(32, 1, 0, 0, 0, 0, 3'd4, 0);
    // Emergency during PED, walk re-requested inside PED
    set_vec(33, 0, 0, 1, 0, 0, 3'd4, 0);
    set_vec(34, 0, 0, 0, 0, 0, 3'd5, 0);
    set_vec(35, 0, 0, 0, 0, 0, 3'd6, 1);
    set_vec(36, 0, 0, 1, 1, 1, 3'd6, 0);
    set_vec(37, 0, 0, 0, 1, 1, 3'd6, 0);
    set_vec(38, 0, 0, 0, 1, 1, 3'd6, 0);
    set_vec(39, 0, 0, 0, 1, 1, 3'd3, 0);
    set_vec(40, 0, 0, 0, 1, 1, 3'd3, 0);
    set_vec(41, 0, 0, 0, 1, 1, 3'd3, 0);
    set_vec(42, 0, 0, 0, 0, 0, 3'd3, 0);
    set_vec(43, 0, 0, 0, 0, 0, 3'd3, 0);
    set_vec(44, 0, 0, 0, 0, 0, 3'd4, 0);
    // After mid-phase reset: no cars, rests in NS_G
    for (int i = 45; i < NVEC; i++) set_vec(i, 0, 0, 0, 0, 0, 3'd0, 0);

    rst = 1'b1; tick = 1'b0; ns_car = 1'b0; ew_car = 1'b0;
    ped_req = 1'b0; emg_req = 1'b0; emg_dir = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("reset", 3'd0);
    check("reset.ped_ack", int'(ped_ack), 0);
    check("reset.tick_cnt", int'(dut.tick_cnt), 0);
    check("reset.ped_pending", int'(dut.ped_pending_reg), 0);
    $display("reset: phase=%0d", phase);

    run_vecs(0, 20);

    // EW emergency in NS_G at tick_cnt=1: yellow on the very next clock, no tick
    emg_req = 1'b1; emg_dir = 1'b1; tick = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("preempt", 3'd1);
    $display("preempt: phase=%0d", phase);

    run_vecs(21, 44);

    check("pre_rst.ped_pending", int'(dut.ped_pending_reg), 1);
    ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0; emg_req = 1'b0; emg_dir = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs("mid_rst", 3'd0);
    check("mid_rst.ped_pending", int'(dut.ped_pending_reg), 0);
    check("mid_rst.tick_cnt", int'(dut.tick_cnt), 0);
    $display("mid_rst: phase=%0d", phase);

    run_vecs(45, NVEC - 1);
    check("rest.tick_cnt", int'(dut.tick_cnt), 4);
    $display("rest: tick_cnt=%0d", dut.tick_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Actuated signal-phase scheduler for a two-way intersection. It sequences NS/EW green, yellow and all-red phases from a once-per-second tick. Green hand-over is driven by vehicle sensors, latched pedestrian walk requests and emergency-vehicle preemption. It drives the six lamp outputs, a walk lamp and a phase code used by the display and logging blocks.

## Interface
- G_MIN, 5: minimum green duration, ticks (≥1)
- Y_TICKS, 2: yellow duration, ticks (≥1)
- AR_TICKS, 1: all-red clearance duration, ticks (≥1)
- WALK_TICKS, 4: pedestrian walk phase duration, ticks (≥1)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle pulse, once per second
- ns_car  in  1  level; vehicle waiting on NS approach
- ew_car  in  1  level; vehicle waiting on EW approach
- ped_req  in  1  pulse or level; pedestrian button
- emg_req  in  1  level; emergency vehicle approaching
- emg_dir  in  1  0 = NS, 1 = EW; valid while emg_req
- ns_g, ns_y, ns_r  out  1 each  NS lamps
- ew_g, ew_y, ew_r  out  1 each  EW lamps
- walk  out  1  walk lamp, high only in PED
- ped_ack  out  1  one-cycle pulse on entry to PED
- phase  out  3  current state encoding

## Operation
- States and encoding: NS_G=0, NS_Y=1, NS_AR=2, EW_G=3, EW_Y=4, EW_AR=5, PED=6. Code 7 is illegal and recovers to NS_AR on the next clock.
- Lamps are a Moore decode of state. Exactly one lamp per direction is lit:
  - NS_G: ns_g, ew_r
  - NS_Y: ns_y, ew_r
  - EW_G: ew_g, ns_r
  - EW_Y: ew_y, ns_r
  - NS_AR, EW_AR and PED: ns_r, ew_r (PED also lights walk)
- tick_cnt counts ticks spent in the current state and clears on every state change. A state of duration N exits on the cycle where tick=1 and tick_cnt=N-1.
- Green exit (NS_G to NS_Y, EW_G to EW_Y):
  - Normal exit: tick=1, tick_cnt ≥ G_MIN-1, and demand present. Demand is the cross-direction car (ew_car for NS_G, ns_car for EW_G) or ped_pending.
  - With no demand, the controller rests in green indefinitely. tick_cnt saturates at G_MIN-1.
  - Preemption exit: emg_req=1 with emg_dir opposite the current green moves to yellow on the next clock. This needs no tick and bypasses G_MIN.
  - Hold: emg_req=1 with emg_dir equal to the current green blocks every exit, including demand.
- Yellow: always exactly Y_TICKS; never shortened.
- All-red: always exactly AR_TICKS. At exit, the next state is chosen in this priority:
  1. emg_req=1: green of emg_dir.
  2. ped_pending=1: PED.
  3. Otherwise: the opposite green (NS_AR→EW_G, EW_AR→NS_G).
- PED: runs the full WALK_TICKS even if emg_req rises. At exit:
  - emg_req=1: green of emg_dir.
  - Otherwise: the green opposite last_dir.
- last_dir is a register that records the direction of the most recent green, updated on each green entry.
- ped_pending:
  - Set by ped_req=1 in any state.
  - Cleared on the clock that enters PED. If ped_req=1 on that same clock, set wins, so the request is served in a later cycle.
- Reset values:
  - state=NS_G, tick_cnt=0, ped_pending=0, last_dir=NS.
  - Outputs: ns_g=1, ew_r=1, every other lamp 0, walk=0, ped_ack=0, phase=0.
- rst mid-phase aborts immediately to the reset values. A pending pedestrian request is discarded.

## Timing
- Transition conditions are evaluated combinationally. State is registered, so lamps, phase and walk change one clock after the qualifying tick or emg_req cycle.
- ped_ack is high during the first clock in PED.
- Between two greens at least Y_TICKS+AR_TICKS ticks elapse, plus WALK_TICKS if PED intervenes.
- A tick coincident with a state change is consumed by the transition. The new state's count starts at 0.
- Sensor inputs are sampled only on qualifying clocks; no debouncing happens in this block.

## Structure
- Shared package holds:
  - state encoding localparams
  - DIR_NS=0 / DIR_EW=1
  - a lamp-vector helper constant per state
- Sub-module phase_timer: tick counter with sync clear, saturation at a limit input, and a terminal flag (tick && cnt==limit-1). The scheduler muxes limit by state. Counter width is $clog2 of the largest parameter, plus 1.

## Test plan
Default parameters; tick every 4 clocks.
- Reset, then no cars: rests in NS_G indefinitely with ns_g=1, ew_r=1. tick_cnt holds at 4.
- ew_car=1 from tick 0: NS_G lasts 5 ticks, NS_Y 2, NS_AR 1, then EW_G. phase steps 0→1→2→3.
- ped_req pulse during EW_G, no cars: 5 ticks EW_G, then EW_Y, then EW_AR. PED follows with walk=1 for 4 ticks and ped_ack for 1 clock, then NS_G.
- emg_req=1, emg_dir=EW at tick_cnt=1 of NS_G: NS_Y on the next clock, then NS_AR, then EW_G. EW_G holds while emg_req=1 despite ns_car=1.
- emg_req=1 during PED: PED completes all 4 ticks, then the emg_dir green is entered. ped_req during PED re-sets ped_pending.
- rst asserted in EW_Y: the next clock shows state NS_G, ns_g=1, ew_r=1, ped_pending=0.
